// File: rtl/mem_lsu_if.sv
// ---------------------------------------------------------------------------
// mem_lsu_if
// Byte-wide RAM port between the MEM-stage load/store unit and the RAM.
//   ram_addr : byte address driven by the LSU
//   ram_wr   : write strobe driven by the LSU
//   ram_dout : write data driven by the LSU
//   ram_din  : read data from the RAM, valid the cycle after its address
// master = LSU side, slave = RAM side.
// ---------------------------------------------------------------------------
interface mem_lsu_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_wr;
    logic [7:0]            ram_dout;
    logic [7:0]            ram_din;

    modport master (
        output ram_addr,
        output ram_wr,
        output ram_dout,
        input  ram_din
    );

    modport slave (
        input  ram_addr,
        input  ram_wr,
        input  ram_dout,
        output ram_din
    );
endinterface

// File: rtl/mem_lsu.sv
// ---------------------------------------------------------------------------
// mem_lsu
// MEM-stage load/store unit. Each load/store held in ex_mem is executed as a
// little-endian byte-serial access over the 8-bit RAM port. stallreq_mem is
// raised until the access completes, then the write-back result is offered
// to mem_wb.
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   req_*              : memory instruction from ex_mem
//   hold               : mem_wb stall bit
//   ram                : byte-wide RAM port (master side)
//   stallreq_mem       : stall request to the stall controller
//   wb_valid/data/rd/wreg : write-back result for mem_wb
// ---------------------------------------------------------------------------
module mem_lsu #(
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    input  logic                      req_we,
    input  logic [1:0]                req_size,
    input  logic                      req_signed,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [31:0]               req_wdata,
    input  logic [REG_ADDR_WIDTH-1:0] req_rd,
    input  logic                      hold,
    mem_lsu_if.master                 ram,
    output logic                      stallreq_mem,
    output logic                      wb_valid,
    output logic [31:0]               wb_data,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd,
    output logic                      wb_wreg
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [2:0]                  cnt_q, cnt_d;
    logic [31:0]                 asm_q, asm_d;
    logic                        we_q, we_d;
    logic                        signed_q, signed_d;
    logic [2:0]                  len_q, len_d;
    logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
    logic [31:0]                 wdata_q, wdata_d;
    logic [REG_ADDR_WIDTH-1:0]   rd_q, rd_d;

    logic [2:0]                  req_len;
    logic [1:0]                  lane;
    logic [31:0]                 ext_data;

    // The whole instruction is latched on acceptance so the access finishes
    // consistently even if ex_mem misbehaves mid-access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            asm_q    <= '0;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            len_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            asm_q    <= asm_d;
            we_q     <= we_d;
            signed_q <= signed_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
        end
    end

    // Next-state and output logic. Byte 0 is issued combinationally in the
    // accept cycle; the remaining bytes follow one per cycle. A load needs
    // one extra cycle because RAM read data lags its address by a cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        asm_d    = asm_q;
        we_d     = we_q;
        signed_d = signed_q;
        len_d    = len_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;

        ram.ram_addr = '0;
        ram.ram_wr   = 1'b0;
        ram.ram_dout = '0;
        stallreq_mem = 1'b0;
        wb_valid     = 1'b0;
        wb_data      = '0;
        wb_rd        = '0;
        wb_wreg      = 1'b0;

        case (req_size)
            2'b00:   req_len = 3'd1;
            2'b01:   req_len = 3'd2;
            default: req_len = 3'd4;
        endcase

        // Read data arriving now belongs to the byte issued last cycle.
        lane = cnt_q[1:0] - 2'd1;

        case (len_q)
            3'd1:    ext_data = {{24{signed_q & asm_q[7]}}, asm_q[7:0]};
            3'd2:    ext_data = {{16{signed_q & asm_q[15]}}, asm_q[15:0]};
            default: ext_data = asm_q;
        endcase

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    stallreq_mem = 1'b1;
                    ram.ram_addr = req_addr;
                    ram.ram_wr   = req_we;
                    ram.ram_dout = req_we ? req_wdata[7:0] : 8'h00;
                    we_d         = req_we;
                    signed_d     = req_signed;
                    len_d        = req_len;
                    addr_d       = req_addr;
                    wdata_d      = req_wdata;
                    rd_d         = req_rd;
                    asm_d        = '0;
                    cnt_d        = 3'd1;
                    // A byte store is finished by the single write above.
                    state_d      = (req_we && (req_len == 3'd1)) ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                stallreq_mem = 1'b1;
                if (!we_q) begin
                    asm_d[{lane, 3'b000} +: 8] = ram.ram_din;
                end
                if (cnt_q < len_q) begin
                    ram.ram_addr = addr_q + {{(ADDR_WIDTH-3){1'b0}}, cnt_q};
                    ram.ram_wr   = we_q;
                    ram.ram_dout = we_q ? wdata_q[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;
                end
                cnt_d = cnt_q + 3'd1;
                if (we_q && (cnt_q == len_q - 3'd1)) begin
                    state_d = DONE;
                end else if (!we_q && (cnt_q == len_q)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                wb_valid = 1'b1;
                wb_rd    = rd_q;
                wb_wreg  = !we_q;
                wb_data  = we_q ? 32'h0 : ext_data;
                if (!hold) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs must collapse the instant reset asserts, even though the
        // IDLE decode above would otherwise react to req_valid.
        if (!rst) begin
            ram.ram_addr = '0;
            ram.ram_wr   = 1'b0;
            ram.ram_dout = '0;
            stallreq_mem = 1'b0;
            wb_valid     = 1'b0;
            wb_data      = '0;
            wb_rd        = '0;
            wb_wreg      = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// ---------------------------------------------------------------------------
// tb_mem_lsu
// Self-checking bench for mem_lsu: a RAM slave plus a byte-addressed
// reference memory that predicts load results, write sequences and stall
// lengths from the access rules.
// ---------------------------------------------------------------------------
module tb_mem_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        hold;
    logic        stallreq_mem;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_wreg;

    int err_count;
    int check_count;

    logic [7:0] ram_mem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    mem_lsu_if #(.ADDR_WIDTH(32)) ram_bus ();

    mem_lsu #(
        .ADDR_WIDTH(32),
        .REG_ADDR_WIDTH(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_we(req_we),
        .req_size(req_size),
        .req_signed(req_signed),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_rd(req_rd),
        .hold(hold),
        .ram(ram_bus.master),
        .stallreq_mem(stallreq_mem),
        .wb_valid(wb_valid),
        .wb_data(wb_data),
        .wb_rd(wb_rd),
        .wb_wreg(wb_wreg)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Untouched memory holds an address-derived pattern.
    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        if (ram_mem.exists(a)) return ram_mem[a];
        return init_byte(a);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    // RAM slave: registered read, write on the strobe.
    always @(posedge clk) begin
        ram_bus.ram_din <= ram_byte(ram_bus.ram_addr);
        if (ram_bus.ram_wr) ram_mem[ram_bus.ram_addr] = ram_bus.ram_dout;
    end

    function automatic int size_len(input logic [1:0] size);
        if (size == 2'b00) return 1;
        if (size == 2'b01) return 2;
        return 4;
    endfunction

    // Reference load value: gather bytes little-endian, then extend.
    function automatic logic [31:0] model_load(input logic [31:0] addr,
                                               input logic [1:0] size,
                                               input logic sgn);
        int n;
        logic [31:0] v;
        n = size_len(size);
        v = 32'h0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = ref_byte(addr + 32'(k));
        if (sgn && n < 4 && v[8*n-1]) begin
            for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
        end
        return v;
    endfunction

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        ram_mem[a] = d;
        ref_mem[a] = d;
    endtask

    // Runs one instruction from the accept cycle through DONE (with an
    // optional hold period) and checks every cycle against the model.
    task automatic applyStimulus(input logic we, input logic [1:0] size,
                                 input logic sgn, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [4:0] rd,
                                 input int hold_cycles,
                                 output logic [31:0] obs_data);
        int n;
        int k;
        int exp_stall;
        logic [31:0] exp_data;
        logic [31:0] exp_addr;
        logic        exp_wr;

        n         = size_len(size);
        exp_stall = we ? n : n + 1;
        exp_data  = we ? 32'h0 : model_load(addr, size, sgn);

        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
        hold       = 1'b0;

        k = 0;
        #1;
        while (stallreq_mem && k < 20) begin
            exp_addr = (k < n) ? addr + 32'(k) : 32'h0;
            exp_wr   = we && (k < n);
            checkOutput("ram_addr", ram_bus.ram_addr, exp_addr);
            checkOutput("ram_wr", {31'h0, ram_bus.ram_wr}, {31'h0, exp_wr});
            if (exp_wr) checkOutput("ram_dout", {24'h0, ram_bus.ram_dout}, {24'h0, wdata[8*k +: 8]});
            k++;
            @(negedge clk);
            #1;
        end
        checkOutput("stall_cycles", 32'(k), 32'(exp_stall));

        obs_data = wb_data;
        checkOutput("wb_valid", {31'h0, wb_valid}, 32'h1);
        checkOutput("wb_wreg", {31'h0, wb_wreg}, {31'h0, !we});
        checkOutput("wb_rd", {27'h0, wb_rd}, {27'h0, rd});
        checkOutput("wb_data", wb_data, exp_data);
        checkOutput("done_ram_wr", {31'h0, ram_bus.ram_wr}, 32'h0);

        if (we) begin
            for (int j = 0; j < n; j++) begin
                ref_mem[addr + 32'(j)] = wdata[8*j +: 8];
                checkOutput("mem_byte", {24'h0, ram_byte(addr + 32'(j))},
                            {24'h0, ref_byte(addr + 32'(j))});
            end
        end

        if (hold_cycles > 0) begin
            hold = 1'b1;
            for (int h = 0; h < hold_cycles; h++) begin
                @(negedge clk);
                #1;
                checkOutput("hold_wb_valid", {31'h0, wb_valid}, 32'h1);
                checkOutput("hold_wb_data", wb_data, exp_data);
                checkOutput("hold_stall", {31'h0, stallreq_mem}, 32'h0);
                checkOutput("hold_ram_wr", {31'h0, ram_bus.ram_wr}, 32'h0);
                checkOutput("hold_ram_addr", ram_bus.ram_addr, 32'h0);
            end
        end
        hold      = 1'b0;
        req_valid = 1'b0;
    endtask

    // Watchdog so a stuck design can never hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] obs;
        logic [31:0] r_addr;
        logic        r_we;
        logic [1:0]  r_size;

        err_count   = 0;
        check_count = 0;
        rst         = 1'b0;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_size    = 2'b00;
        req_signed  = 1'b0;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        req_rd      = 5'h0;
        hold        = 1'b0;

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("reset_stall", {31'h0, stallreq_mem}, 32'h0);
        checkOutput("reset_wb_valid", {31'h0, wb_valid}, 32'h0);
        checkOutput("reset_ram_wr", {31'h0, ram_bus.ram_wr}, 32'h0);
        checkOutput("reset_ram_addr", ram_bus.ram_addr, 32'h0);

        // Word load of 11,22,33,44.
        preload(32'h100, 8'h11);
        preload(32'h101, 8'h22);
        preload(32'h102, 8'h33);
        preload(32'h103, 8'h44);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd7, 0, obs);
        checkOutput("tp_word_load", obs, 32'h44332211);

        // Sign/zero extension cases.
        preload(32'h180, 8'h80);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h180, 32'h0, 5'd3, 0, obs);
        checkOutput("tp_sbyte", obs, 32'hFFFFFF80);
        preload(32'h190, 8'h80);
        preload(32'h191, 8'hFF);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h190, 32'h0, 5'd4, 0, obs);
        checkOutput("tp_uhalf", obs, 32'h0000FF80);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h190, 32'h0, 5'd5, 0, obs);
        checkOutput("tp_shalf", obs, 32'hFFFFFF80);

        // Word store, then read it back through the design.
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h200, 32'hDEADBEEF, 5'd9, 0, obs);
        checkOutput("tp_store_ram3", {24'h0, ram_byte(32'h203)}, 32'h000000DE);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h200, 32'h0, 5'd10, 0, obs);
        checkOutput("tp_store_readback", obs, 32'hDEADBEEF);

        // Half load across the top of the address space.
        preload(32'hFFFFFFFF, 8'h34);
        preload(32'h00000000, 8'h12);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0, 5'd11, 0, obs);
        checkOutput("tp_wrap", obs, 32'h00001234);

        // Hold in DONE, then back-to-back load and store.
        applyStimulus(1'b0, 2'b10, 1'b1, 32'h100, 32'h0, 5'd12, 3, obs);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 5'd13, 0, obs);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000A5C3, 5'd14, 0, obs);

        // Randomized mix.
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 3))
                0:       r_addr = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
                1:       r_addr = 32'h00000400 + 32'($urandom_range(0, 15));
                default: r_addr = 32'h00000500 + 32'($urandom_range(0, 15));
            endcase
            r_we   = 1'($urandom_range(0, 1));
            r_size = 2'($urandom_range(0, 3));
            applyStimulus(r_we, r_size, 1'($urandom_range(0, 1)), r_addr, $urandom,
                          5'($urandom_range(0, 31)), int'($urandom_range(0, 2)), obs);
        end

        // Reset during cycle 2 of a word store.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_addr   = 32'h300;
        req_wdata  = 32'h87654321;
        req_rd     = 5'd1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("pre_reset_ram_wr", {31'h0, ram_bus.ram_wr}, 32'h1);
        rst = 1'b0;
        #1;
        checkOutput("rst_ram_wr", {31'h0, ram_bus.ram_wr}, 32'h0);
        checkOutput("rst_ram_addr", ram_bus.ram_addr, 32'h0);
        checkOutput("rst_ram_dout", {24'h0, ram_bus.ram_dout}, 32'h0);
        checkOutput("rst_stall", {31'h0, stallreq_mem}, 32'h0);
        checkOutput("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
        checkOutput("rst_wb_data", wb_data, 32'h0);
        checkOutput("rst_wb_wreg", {31'h0, wb_wreg}, 32'h0);
        req_valid = 1'b0;
        ref_mem[32'h300] = 8'h21;
        ref_mem[32'h301] = 8'h43;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            checkOutput("post_rst_stall", {31'h0, stallreq_mem}, 32'h0);
            checkOutput("post_rst_wb_valid", {31'h0, wb_valid}, 32'h0);
            checkOutput("post_rst_ram_wr", {31'h0, ram_bus.ram_wr}, 32'h0);
        end
        for (int j = 0; j < 4; j++) begin
            checkOutput("partial_store_mem", {24'h0, ram_byte(32'h300 + 32'(j))},
                        {24'h0, ref_byte(32'h300 + 32'(j))});
        end

        // The design must still work normally after the interrupted store.
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 5'd2, 0, obs);

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
